// File: rtl/ps2_scancode_sequencer_pkg.sv
// Shared constants, FSM state and event record for the PS/2 set-2 scancode sequencer.
package ps2_scancode_sequencer_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERRF   = 8'hFF;
  localparam int         PAUSE_TAIL = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] codigo;
    logic       suelta;
    logic       extendido;
  } evento_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK) || (b == SC_PAUSE);
  endfunction

  // Keyboard status/response bytes that never carry a key code.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
           (b == SC_ERR0) || (b == SC_ERRF);
  endfunction

endpackage

// File: rtl/ps2_scancode_sequencer_fifo_eventos.sv
// Synchronous FIFO of 10-bit key events; head is read combinationally from storage.
module fifo_eventos
  import ps2_scancode_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [9:0] din,
  output logic [9:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [9:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_q];

  always_comb begin
    // A pop frees the slot this same cycle, so a full FIFO still accepts the push.
    do_push = push & (~full | pop);
    do_pop  = pop & ~empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_scancode_sequencer.sv
// Decodes PS/2 set-2 prefix sequences (E0/F0/E1) into key events, with timeout
// recovery, and hands them to the consumer through an event FIFO.
module ps2_scancode_sequencer
  import ps2_scancode_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dato_entrada,
  input  logic       rx_listo,
  output logic [7:0] evento_codigo,
  output logic       evento_suelta,
  output logic       evento_extendido,
  output logic       evento_valido,
  input  logic       evento_ack,
  output logic       desborde,
  output logic       error_timeout
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       pause_q, pause_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rx_q, rx_d;
  logic             err_q, err_d;
  logic             desborde_q, desborde_d;

  logic             strobe;
  logic             push, pop, fifo_full, fifo_empty;
  evento_t          ev_in, head;
  logic [9:0]       head_raw;

  fifo_eventos #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ev_in),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head             = evento_t'(head_raw);
  assign evento_codigo    = head.codigo;
  assign evento_suelta    = head.suelta;
  assign evento_extendido = head.extendido;
  assign evento_valido    = ~fifo_empty;
  assign pop              = evento_ack & ~fifo_empty;
  assign desborde         = desborde_q;
  assign error_timeout    = err_q;

  always_comb begin
    strobe     = rx_listo & ~rx_q;
    rx_d       = rx_listo;
    state_d    = state_q;
    pause_d    = pause_q;
    tmo_d      = tmo_q;
    err_d      = 1'b0;
    push       = 1'b0;
    ev_in      = '{codigo: dato_entrada, suelta: 1'b0, extendido: 1'b0};

    if (strobe) begin
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (dato_entrada == SC_EXT) begin
            state_d = ST_EXT;
          end else if (dato_entrada == SC_BRK) begin
            state_d = ST_BRK;
          end else if (dato_entrada == SC_PAUSE) begin
            state_d = ST_PAUSE;
            pause_d = 3'(PAUSE_TAIL);
          end else if (!is_ignored(dato_entrada)) begin
            push = 1'b1;
          end
        end
        ST_EXT: begin
          if (dato_entrada == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d         = ST_IDLE;
            push            = ~is_prefix(dato_entrada);
            ev_in.extendido = 1'b1;
          end
        end
        ST_BRK: begin
          state_d      = ST_IDLE;
          push         = ~is_prefix(dato_entrada);
          ev_in.suelta = 1'b1;
        end
        ST_EXT_BRK: begin
          state_d         = ST_IDLE;
          push            = ~is_prefix(dato_entrada);
          ev_in.suelta    = 1'b1;
          ev_in.extendido = 1'b1;
        end
        ST_PAUSE: begin
          // Pause tail bytes are consumed blind; E1/F0 inside it are not prefixes.
          pause_d = pause_q - 3'd1;
          if (pause_q == 3'd1) begin
            state_d = ST_IDLE;
            push    = 1'b1;
            ev_in   = '{codigo: SC_PAUSE, suelta: 1'b0, extendido: 1'b1};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    desborde_d = desborde_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pause_q    <= '0;
      tmo_q      <= '0;
      rx_q       <= 1'b0;
      err_q      <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pause_q    <= pause_d;
      tmo_q      <= tmo_d;
      rx_q       <= rx_d;
      err_q      <= err_d;
      desborde_q <= desborde_d;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Self-checking bench: byte-sequence reference model compared every cycle, plus literal checks.
module tb_ps2_scancode_sequencer;

  localparam int T     = 20;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dato_entrada;
  logic       rx_listo;
  logic [7:0] evento_codigo;
  logic       evento_suelta;
  logic       evento_extendido;
  logic       evento_valido;
  logic       evento_ack;
  logic       desborde;
  logic       error_timeout;

  ps2_scancode_sequencer #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .dato_entrada     (dato_entrada),
    .rx_listo         (rx_listo),
    .evento_codigo    (evento_codigo),
    .evento_suelta    (evento_suelta),
    .evento_extendido (evento_extendido),
    .evento_valido    (evento_valido),
    .evento_ack       (evento_ack),
    .desborde         (desborde),
    .error_timeout    (error_timeout)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: pending prefix bytes of the current sequence, event queue, flags.
  logic [7:0] seq[$];
  logic [9:0] evq[$];
  logic       m_prev_rx = 1'b0;
  logic       m_des = 1'b0;
  logic       m_err = 1'b0;
  int         m_since = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic is_pfx(input logic [7:0] b);
    return b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
  endfunction

  function automatic logic is_ign(input logic [7:0] b);
    return b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'h00 || b == 8'hFF;
  endfunction

  task automatic model_step(input logic rx, input logic [7:0] d, input logic ack, input logic rst);
    logic       strobe, do_push, pop;
    logic [9:0] ev;
    if (rst) begin
      seq.delete(); evq.delete();
      m_prev_rx = 0; m_des = 0; m_err = 0; m_since = 0;
      return;
    end
    strobe    = rx & ~m_prev_rx;
    m_prev_rx = rx;
    pop       = ack && evq.size() > 0;
    do_push   = 0;
    ev        = '0;
    m_err     = 0;
    if (strobe) begin
      m_since = 0;
      if (seq.size() == 0) begin
        if (is_pfx(d)) seq.push_back(d);
        else if (!is_ign(d)) begin do_push = 1; ev = {d, 2'b00}; end
      end else if (seq[0] == 8'hE1) begin
        seq.push_back(d);
        if (seq.size() == 8) begin do_push = 1; ev = {8'hE1, 2'b01}; seq.delete(); end
      end else if (seq.size() == 1 && seq[0] == 8'hE0 && d == 8'hF0) begin
        seq.push_back(d);
      end else begin
        if (!is_pfx(d)) begin
          do_push = 1;
          ev = {d, (seq[seq.size()-1] == 8'hF0), (seq[0] == 8'hE0)};
        end
        seq.delete();
      end
    end else if (seq.size() != 0) begin
      if (m_since == T - 1) begin seq.delete(); m_err = 1; m_since = 0; end
      else m_since++;
    end
    if (pop) void'(evq.pop_front());
    if (do_push) begin
      if (evq.size() < DEPTH) evq.push_back(ev);
      else m_des = 1;
    end
  endtask

  // One clock: compare outputs against the model, then drive the next inputs.
  task automatic cycle(input logic rx, input logic [7:0] d, input logic ack, input logic rst);
    @(negedge clk);
    check("valid", evento_valido, evq.size() != 0);
    if (evq.size() != 0) check("head", {evento_codigo, evento_suelta, evento_extendido}, evq[0]);
    check("desborde", desborde, m_des);
    check("err", error_timeout, m_err);
    reset = rst; rx_listo = rx; dato_entrada = d; evento_ack = ack;
    model_step(rx, d, ack, rst);
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1, b, 0, 0);
    cycle(0, b, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0);
  endtask

  task automatic ack1();
    cycle(0, 8'h00, 1, 0);
  endtask

  task automatic lit_head(input string name, input logic [9:0] exp);
    check(name, {evento_valido, evento_codigo, evento_suelta, evento_extendido}, {1'b1, exp});
  endtask

  int errs;
  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h1C, 8'h75, 8'h15, 8'hAA, 8'h00, 8'hFF, 8'h2D, 8'h14, 8'h77};

  initial begin
    reset = 1; rx_listo = 0; dato_entrada = 0; evento_ack = 0;
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1); cycle(0, 0, 0, 0);
    idle(1);
    check("reset_outs", {evento_valido, evento_codigo, evento_suelta, evento_extendido, desborde, error_timeout}, '0);

    // Long level yields exactly one event, visible one cycle after the edge.
    cycle(1, 8'h1C, 0, 0);
    cycle(1, 8'h1C, 0, 0);
    lit_head("level_first", {8'h1C, 2'b00});
    for (int i = 0; i < 198; i++) cycle(1, 8'h1C, 0, 0);
    cycle(0, 8'h1C, 0, 0);
    ack1(); idle(1);
    check("level_one_event", evento_valido, 1'b0);

    send(8'hF0); send(8'h1C); idle(1); lit_head("break", {8'h1C, 2'b10}); ack1();
    send(8'hE0); send(8'h75); idle(1); lit_head("ext", {8'h75, 2'b01}); ack1();
    send(8'hE0); send(8'hF0); send(8'h75); idle(1); lit_head("ext_break", {8'h75, 2'b11}); ack1();
    idle(1);

    begin
      logic [7:0] pz [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) send(pz[i]);
    end
    idle(1); lit_head("pause", {8'hE1, 2'b01}); ack1(); idle(1);
    check("pause_single", evento_valido, 1'b0);

    send(8'hAA); send(8'hFA); send(8'hFE); send(8'h00); send(8'hFF);
    idle(1); check("ignored", evento_valido, 1'b0);
    send(8'hE1); send(8'hF0);
    errs = 0;
    for (int i = 0; i < 2 * T; i++) begin cycle(0, 0, 0, 0); errs += int'(error_timeout); end
    check("pause_timeout_pulses", errs, 1);
    check("pause_timeout_noev", evento_valido, 1'b0);

    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); idle(1);
    check("ovf_des", desborde, 1'b1);
    lit_head("ovf_head0", {8'h15, 2'b00}); ack1(); idle(1);
    lit_head("ovf_head1", {8'h1D, 2'b00}); ack1(); idle(1);
    lit_head("ovf_head2", {8'h24, 2'b00}); ack1(); idle(1);
    lit_head("ovf_head3", {8'h2D, 2'b00}); ack1(); idle(1);
    check("ovf_empty", evento_valido, 1'b0);

    cycle(0, 0, 0, 1); cycle(0, 0, 0, 0);
    send(8'hF0);
    errs = 0;
    for (int i = 0; i < T + 5; i++) begin cycle(0, 0, 0, 0); errs += int'(error_timeout); end
    check("brk_timeout_pulses", errs, 1);
    send(8'h1C); idle(1); lit_head("after_timeout", {8'h1C, 2'b00}); ack1();
    send(8'hE0); cycle(0, 0, 0, 1); cycle(0, 0, 0, 0);
    send(8'h75); idle(1); lit_head("after_reset", {8'h75, 2'b00}); ack1();

    // Randomized traffic, checked every cycle against the model.
    for (int it = 0; it < 1500; it++) begin
      int hold, gap;
      logic [7:0] b;
      b    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      hold = $urandom_range(1, 4);
      gap  = ($urandom_range(0, 15) == 0) ? $urandom_range(T - 3, T + 3) : $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) cycle(1, b, ($urandom_range(0, 2) == 0), 0);
      for (int i = 0; i <= gap; i++) cycle(0, b, ($urandom_range(0, 2) == 0), ($urandom_range(0, 400) == 0));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
